// File: rtl/sirv_icb_bram_ctrl.sv
// ---------------------------------------------------------------------------
// sirv_icb_bram_ctrl
// ICB slave front end for a single-port block RAM with 1-cycle read latency
// (sirv_sim_ram family). Each accepted command drives the RAM strobes in the
// same cycle. Its response is captured one cycle later into a 3-entry
// in-order FIFO. Command acceptance depends only on registered occupancy, so
// icb_rsp_ready has no combinational path to icb_cmd_ready.
//
// Optional feature macro: SIRV_BRAM_CTRL_ADDR_CHK_EN
//   When defined, a word index at or above DP is rejected. The RAM is not
//   selected and the response carries err=1 with rdata=0.
//   When undefined, upper address bits alias modulo DP and icb_rsp_err is 0.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   icb_cmd_*                  ICB command channel (valid/ready/addr/read/wdata/wmask)
//   icb_rsp_*                  ICB response channel (valid/ready/rdata/err)
//   ram_cs/we/wem/addr/din     RAM strobes, combinational from the accepted command
//   ram_dout                   RAM read data, valid one cycle after a read cs
// ---------------------------------------------------------------------------
module sirv_icb_bram_ctrl #(
    parameter int unsigned DP     = 512,
    parameter int unsigned DW     = 32,
    parameter int unsigned MW     = DW / 8,
    parameter int unsigned AW     = 32,
    parameter int unsigned RAM_AW = $clog2(DP)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [AW-1:0]     icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [DW-1:0]     icb_cmd_wdata,
    input  logic [MW-1:0]     icb_cmd_wmask,

    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [DW-1:0]     icb_rsp_rdata,
    output logic              icb_rsp_err,

    output logic              ram_cs,
    output logic              ram_we,
    output logic [MW-1:0]     ram_wem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout
);

    localparam int unsigned MW_LG = $clog2(MW);
    localparam int unsigned DEPTH = 3;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 2;

    logic              cmd_fire;
    logic              cmd_err;
    logic              pend;
    logic              pend_rd;
    logic              push;
    logic              pop;
    logic [DW-1:0]     push_rdata;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     fifo_cnt;
    logic [DW-1:0]     fifo_rdata [DEPTH];
    logic              unused_addr_bits;

    // Only the word-index bits reach the RAM; the rest is sunk here.
    assign unused_addr_bits = ^icb_cmd_addr;

    // Wrap-around pointer increment for the 3-entry ring.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pending stage plus FIFO occupancy is bounded by DEPTH, so a push never
    // finds the FIFO full.
    assign icb_cmd_ready = ({1'b0, fifo_cnt} + {2'b00, pend}) < 3'(DEPTH);
    assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;

    // RAM strobes straight from the command channel.
    assign ram_cs   = cmd_fire & ~cmd_err;
    assign ram_we   = ~icb_cmd_read;
    assign ram_wem  = icb_cmd_wmask;
    assign ram_din  = icb_cmd_wdata;
    assign ram_addr = icb_cmd_addr[RAM_AW+MW_LG-1:MW_LG];

`ifdef SIRV_BRAM_CTRL_ADDR_CHK_EN
    logic pend_err;
    logic fifo_err [DEPTH];

    assign cmd_err = (icb_cmd_addr[AW-1:MW_LG] >= (AW - MW_LG)'(DP));

    // Errored reads never selected the RAM, so ram_dout is not meaningful.
    assign push_rdata = (pend_rd & ~pend_err) ? ram_dout : '0;

    // Error flag travels alongside the data through pend and the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo_err[i] <= 1'b0;
        end else begin
            pend_err <= cmd_fire & cmd_err;
            if (push) fifo_err[wptr] <= pend_err;
        end
    end

    assign icb_rsp_err = fifo_err[rptr];
`else
    assign cmd_err     = 1'b0;
    assign push_rdata  = pend_rd ? ram_dout : '0;
    assign icb_rsp_err = 1'b0;
`endif

    // Pending stage: marks the cycle in which ram_dout belongs to the last command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            pend_rd <= 1'b0;
        end else begin
            pend    <= cmd_fire;
            pend_rd <= cmd_fire & icb_cmd_read;
        end
    end

    assign push = pend;
    assign pop  = icb_rsp_valid & icb_rsp_ready;

    // In-order response FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_rdata[i] <= '0;
        end else begin
            if (push) begin
                fifo_rdata[wptr] <= push_rdata;
                wptr             <= ptr_inc(wptr);
            end
            if (pop) rptr <= ptr_inc(rptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign icb_rsp_valid = (fifo_cnt != '0);
    assign icb_rsp_rdata = fifo_rdata[rptr];

endmodule
